// File: rtl/alu_op_sequencer_pkg.sv
// alu_seq_pkg: opcode constants, state/class enums, strobe bundle and opcode classifier
package alu_seq_pkg;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_ROR = 5'b01001;
  localparam logic [4:0] OP_ROL = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
  typedef enum logic [1:0] {BIN, UNA, WIDE, ILL} op_class_t;
  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mdr_read, ir_in;
    logic y_in, y_out, z_in, zlo_out, zhi_out, hi_in, lo_in;
  } strobes_t;
  function automatic op_class_t op_class(input logic [31:0] op);
    case (op)
      32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND), 32'(OP_OR),
      32'(OP_SHR), 32'(OP_SHL), 32'(OP_ROR), 32'(OP_ROL): return BIN;
      32'(OP_NEG), 32'(OP_NOT): return UNA;
      32'(OP_MUL), 32'(OP_DIV): return WIDE;
      default: return ILL;
    endcase
  endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: control-unit handshake plus datapath strobes (master = control unit/bench, slave = sequencer)
interface alu_op_sequencer_if #(parameter int NUM_REGS = 16, parameter int OPC_W = 5);
  import alu_seq_pkg::*;
  localparam int SEL_W = $clog2(NUM_REGS);
  logic start, mem_ready, busy, done, err;
  logic [OPC_W-1:0] opcode, alu_opcode;
  logic [SEL_W-1:0] ra_sel, rb_sel, rd_sel;
  logic [NUM_REGS-1:0] r_out, r_in;
  logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mdr_read, ir_in;
  logic y_in, y_out, z_in, zlo_out, zhi_out, hi_in, lo_in;
  modport master (
    output start, opcode, ra_sel, rb_sel, rd_sel, mem_ready,
    input busy, done, err, r_out, r_in, alu_opcode,
    input pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mdr_read, ir_in,
    input y_in, y_out, z_in, zlo_out, zhi_out, hi_in, lo_in
  );
  modport slave (
    input start, opcode, ra_sel, rb_sel, rd_sel, mem_ready,
    output busy, done, err, r_out, r_in, alu_opcode,
    output pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mdr_read, ir_in,
    output y_in, y_out, z_in, zlo_out, zhi_out, hi_in, lo_in
  );
endinterface

// File: rtl/alu_op_sequencer_onehot_dec.sv
// seq_onehot_dec: index to one-hot decoder with enable (en_i, idx_i in; onehot_o out)
module seq_onehot_dec #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         en_i,
  input  logic [W-1:0] idx_i,
  output logic [N-1:0] onehot_o
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign onehot_o[i] = en_i && idx_i == W'(i);
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetch/execute micro-step sequencer (clk, clr in; bus.slave: start/opcode/ra,rb,rd_sel/mem_ready in, busy/done/err/r_out/r_in/strobes/alu_opcode out, all registered)
module alu_op_sequencer #(
  parameter int NUM_REGS    = 16,
  parameter int OPC_W       = 5,
  parameter int FETCH_EN    = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic clr,
  alu_op_sequencer_if.slave bus
);
  import alu_seq_pkg::*;
  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  state_t state_q, state_d;
  op_class_t cls;
  logic take;
  logic [OPC_W-1:0] op_q, op_d, alu_q, alu_d;
  logic [SEL_W-1:0] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d, ro_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0] r_out_q, r_out_d, r_in_q, r_in_d;
  strobes_t st_q, st_d;
  logic busy_q, done_q, done_d, err_q, err_d, ro_en, ri_en;
  assign take = state_q == IDLE && bus.start;
  assign op_d = take ? bus.opcode : op_q;
  assign ra_d = take ? bus.ra_sel : ra_q;
  assign rb_d = take ? bus.rb_sel : rb_q;
  assign rd_d = take ? bus.rd_sel : rd_q;
  assign cls = op_class(32'(op_d));
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    err_d = 1'b0;
    case (state_q)
      IDLE: state_d = bus.start ? (FETCH_EN != 0 ? T0 : T3) : IDLE;
      T0: state_d = T1;
      T1:
        if (bus.mem_ready) state_d = T2;
        else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      T2: state_d = T3;
      T3: begin
        state_d = cls == ILL ? IDLE : T4;
        err_d = cls == ILL;
      end
      T4: state_d = cls == UNA ? IDLE : T5;
      T5: state_d = cls == WIDE ? T6 : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Strobes are decoded for the state being entered and then registered, so each
  // output is a flop that holds for the entire cycle of its state.
  always_comb begin
    st_d = '0;
    ro_en = 1'b0;
    ri_en = 1'b0;
    ro_idx = ra_d;
    alu_d = '0;
    done_d = 1'b0;
    case (state_d)
      T0: {st_d.pc_out, st_d.mar_in, st_d.inc_pc, st_d.z_in} = 4'hF;
      T1: {st_d.zlo_out, st_d.pc_in, st_d.mdr_read, st_d.mdr_in} = 4'hF;
      T2: {st_d.mdr_out, st_d.ir_in} = 2'b11;
      T3:
        if (cls != ILL) begin
          ro_en = 1'b1;
          st_d.y_in = cls != UNA;
          st_d.z_in = cls == UNA;
          alu_d = cls == UNA ? op_d : '0;
        end
      T4:
        if (cls == UNA) begin
          st_d.zlo_out = 1'b1;
          ri_en = 1'b1;
          done_d = 1'b1;
        end else begin
          ro_en = 1'b1;
          ro_idx = rb_d;
          st_d.z_in = 1'b1;
          alu_d = op_d;
        end
      T5: begin
        st_d.zlo_out = 1'b1;
        st_d.lo_in = cls == WIDE;
        ri_en = cls == BIN;
        done_d = cls == BIN;
      end
      T6: {st_d.zhi_out, st_d.hi_in, done_d} = 3'b111;
      default: ;
    endcase
  end
  seq_onehot_dec #(.N(NUM_REGS)) u_rout (.en_i(ro_en), .idx_i(ro_idx), .onehot_o(r_out_d));
  seq_onehot_dec #(.N(NUM_REGS)) u_rin (.en_i(ri_en), .idx_i(rd_d), .onehot_o(r_in_d));
  always_ff @(posedge clk)
    if (clr) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rd_q <= '0;
      st_q <= '0;
      alu_q <= '0;
      r_out_q <= '0;
      r_in_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      rd_q <= rd_d;
      st_q <= st_d;
      alu_q <= alu_d;
      r_out_q <= r_out_d;
      r_in_q <= r_in_d;
      busy_q <= state_d != IDLE;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.r_out = r_out_q;
  assign bus.r_in = r_in_q;
  assign bus.alu_opcode = alu_q;
  assign {bus.pc_out, bus.pc_in, bus.inc_pc, bus.mar_in, bus.mdr_in, bus.mdr_out, bus.mdr_read, bus.ir_in,
          bus.y_in, bus.y_out, bus.z_in, bus.zlo_out, bus.zhi_out, bus.hi_in, bus.lo_in} = st_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;
  localparam int MEM_TIMEOUT = 15;
  localparam int PC_OUT = 0, PC_IN = 1, INC_PC = 2, MAR_IN = 3, MDR_IN = 4, MDR_OUT = 5, MDR_READ = 6, IR_IN = 7;
  localparam int Y_IN = 8, Y_OUT = 9, Z_IN = 10, ZLO = 11, ZHI = 12, HI_IN = 13, LO_IN = 14;
  typedef struct packed {
    logic busy, done, err;
    logic [15:0] r_out, r_in;
    logic [14:0] st;
    logic [4:0] alu;
  } obs_t;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  alu_op_sequencer_if #(.NUM_REGS(16), .OPC_W(5)) bus ();
  alu_op_sequencer #(.NUM_REGS(16), .OPC_W(5), .FETCH_EN(1), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );
  obs_t exp_q[$];
  obs_t seq[$];
  obs_t obs, want;
  int checks = 0;
  int failures = 0;
  bit mon_en = 0;
  logic [4:0] legal [12] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17};
  assign obs = {bus.busy, bus.done, bus.err, bus.r_out, bus.r_in,
                bus.lo_in, bus.hi_in, bus.zhi_out, bus.zlo_out, bus.z_in, bus.y_out, bus.y_in,
                bus.ir_in, bus.mdr_read, bus.mdr_out, bus.mdr_in, bus.mar_in, bus.inc_pc, bus.pc_in, bus.pc_out,
                bus.alu_opcode};
  function automatic logic [14:0] b(int k);
    return 15'(1) << k;
  endfunction
  function automatic obs_t e(logic [14:0] st, int ro, int ri, logic [4:0] alu, bit dn);
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    o.done = dn;
    o.r_out = ro < 0 ? 16'h0 : 16'(1) << ro;
    o.r_in = ri < 0 ? 16'h0 : 16'(1) << ri;
    o.st = st;
    o.alu = alu;
    return o;
  endfunction
  task automatic check(string name, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
    end
  endtask
  // Expected per-cycle observation list for one instruction, straight from the step table.
  task automatic build(logic [4:0] op, int ra, int rb, int rd, int waits);
    obs_t er;
    er = '0;
    er.err = 1'b1;
    seq.delete();
    seq.push_back(e(b(PC_OUT) | b(MAR_IN) | b(INC_PC) | b(Z_IN), -1, -1, 0, 0));
    for (int j = 0; j <= waits && j < MEM_TIMEOUT; j++)
      seq.push_back(e(b(ZLO) | b(PC_IN) | b(MDR_READ) | b(MDR_IN), -1, -1, 0, 0));
    if (waits >= MEM_TIMEOUT) begin
      seq.push_back(er);
      return;
    end
    seq.push_back(e(b(MDR_OUT) | b(IR_IN), -1, -1, 0, 0));
    if (op inside {5'd16, 5'd17}) begin
      seq.push_back(e(b(Z_IN), ra, -1, op, 0));
      seq.push_back(e(b(ZLO), -1, rd, 0, 1));
    end else if (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15}) begin
      seq.push_back(e(b(Y_IN), ra, -1, 0, 0));
      seq.push_back(e(b(Z_IN), rb, -1, op, 0));
      if (op inside {5'd14, 5'd15}) begin
        seq.push_back(e(b(ZLO) | b(LO_IN), -1, -1, 0, 0));
        seq.push_back(e(b(ZHI) | b(HI_IN), -1, -1, 0, 1));
      end else seq.push_back(e(b(ZLO), -1, rd, 0, 1));
    end else begin
      seq.push_back(e(15'h0, -1, -1, 0, 0));
      seq.push_back(er);
    end
  endtask
  // Called at a negedge where the DUT is idle; returns at the negedge of its next idle cycle.
  task automatic run(logic [4:0] op, int ra, int rb, int rd, int waits, int clr_at = 0);
    int n, l;
    build(op, ra, rb, rd, waits);
    n = seq.size();
    l = seq[n-1].busy ? n : n - 1;
    for (int i = 0; i < (clr_at > 0 ? clr_at : n); i++) exp_q.push_back(seq[i]);
    bus.start = 1'b1;
    bus.opcode = op;
    bus.ra_sel = 4'(ra);
    bus.rb_sel = 4'(rb);
    bus.rd_sel = 4'(rd);
    for (int i = 1; i <= l; i++) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(1));
      bus.opcode = 5'($urandom);
      bus.ra_sel = 4'($urandom);
      bus.rb_sel = 4'($urandom);
      bus.rd_sel = 4'($urandom);
      bus.mem_ready = i >= waits + 2;
      if (i == clr_at) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        bus.start = 1'b0;
        return;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  always @(negedge clk)
    if (mon_en) begin
      if (obs.busy || obs.err) begin
        want = exp_q.size() > 0 ? exp_q.pop_front() : obs_t'(0);
        check("step", obs, want);
      end else check("idle", obs, obs_t'(0));
    end
  initial begin
    bus.start = 1'b0;
    bus.opcode = '0;
    bus.ra_sel = '0;
    bus.rb_sel = '0;
    bus.rd_sel = '0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    mon_en = 1;
    @(negedge clk);
    run(5'b00011, 2, 3, 1, 0);
    @(negedge clk);
    run(5'b10001, 1, 5, 0, 0);
    run(5'b01110, 6, 3, 5, 0);
    run(5'b00011, 4, 4, 7, 4);
    run(5'b00100, 1, 2, 3, 20);
    run(5'b11111, 1, 2, 3, 0);
    @(negedge clk);
    run(5'b01111, 1, 2, 3, 0, 5);
    run(5'b00011, 9, 10, 11, 0);
    for (int k = 0; k < 80; k++) begin
      logic [4:0] op;
      int w;
      op = $urandom_range(3) == 0 ? 5'($urandom) : legal[$urandom_range(11)];
      w = $urandom_range(9) == 0 ? int'($urandom_range(18, 14)) : int'($urandom_range(3));
      run(op, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)), w);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised hardwired micro-step sequencer for register-register ALU instructions.
- Generates every datapath control strobe for the fetch and execute steps: T0–T2 fetch, then T3–T6 execute.
- Handles binary, unary (NEG/NOT) and 64-bit-result (MUL/DIV) opcode classes.
- Sits beside the datapath in place of hand-driven bench sequencing, with a start/busy/done handshake toward the future control unit.

Parameters:
- NUM_REGS, 16, number of general registers; width of the one-hot r_out/r_in vectors (power of two, ≥2).
- OPC_W, 5, ALU opcode width.
- FETCH_EN, 1, 1 = run T0–T2 fetch before execute; 0 = start directly at T3.
- MEM_TIMEOUT, 15, maximum cycles T1 waits for mem_ready before aborting (≥1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  reset; synchronous, active-high.
- start  in  1  request an instruction; sampled only in IDLE.
- opcode  in  OPC_W  ALU operation; latched on accepted start.
- ra_sel  in  $clog2(NUM_REGS)  source A index; latched on accepted start.
- rb_sel  in  $clog2(NUM_REGS)  source B index; latched on accepted start.
- rd_sel  in  $clog2(NUM_REGS)  destination index; latched on accepted start.
- mem_ready  in  1  memory read data valid.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse on illegal opcode or memory timeout.
- r_out  out  NUM_REGS  one-hot register-to-bus enables.
- r_in  out  NUM_REGS  one-hot register load enables.
- pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mdr_read, ir_in  out  1 each  fetch-path strobes.
- y_in, y_out, z_in, zlo_out, zhi_out, hi_in, lo_in  out  1 each  ALU-path strobes.
- alu_opcode  out  OPC_W  opcode presented to the ALU.

Behaviour:
- Reset (clr high at an edge): state = IDLE, timeout counter = 0, latched fields = 0, all outputs = 0. Applies mid-operation; no partial strobe survives the edge.
- Strobe timing: all strobes and alu_opcode are decoded from the registered state plus latched fields only, never directly from inputs. They are stable for the whole cycle of their state. Outside the listed states they are 0, and alu_opcode is 0.
- IDLE: when start = 1, latch opcode and the three selects, then go to T0 if FETCH_EN = 1, else T3. start while busy is ignored.
- T0: pc_out, mar_in, inc_pc, z_in high. Go to T1.
- T1: zlo_out, pc_in, mdr_read, mdr_in high.
  - Holds while mem_ready = 0; the counter increments each held cycle.
  - mem_ready = 1 → T2, counter cleared.
  - Counter reaches MEM_TIMEOUT with mem_ready = 0 → IDLE with an err pulse.
- T2: mdr_out, ir_in high. Go to T3.
- Opcode classes: class is decoded from the latched opcode using the package constants. Any opcode not in the package → IDLE from T3 with an err pulse; no r_in asserted.
- Binary class:
  - T3: r_out[ra] and y_in high.
  - T4: r_out[rb], z_in, alu_opcode valid.
  - T5: zlo_out and r_in[rd] high, done pulse, then IDLE.
- Unary class (NEG, NOT):
  - T3: r_out[ra], z_in, alu_opcode valid; Y is not used.
  - T4: zlo_out and r_in[rd] high, done pulse, then IDLE.
- Wide class (MUL, DIV):
  - T3 and T4 as for the binary class.
  - T5: zlo_out and lo_in high.
  - T6: zhi_out and hi_in high, done pulse, then IDLE. rd is ignored.
- One-hot rule: r_out and r_in are each one-hot or zero, never multi-hot. rd = 0 is legal. ra = rb is legal; the same enable is asserted in T3 and T4.
- Output handshake: done and err are never high together. busy drops in the same cycle that IDLE is re-entered.
- Back-to-back: start held high re-launches on the cycle after done. Minimum instruction period = execute length + 1 idle cycle.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010, MUL 01110, DIV 01111, NEG 10000, NOT 10001;
  - state enum IDLE, T0–T6;
  - class enum BIN/UNA/WIDE/ILL, plus function op_class(opcode).
- One sub-module: seq_onehot_dec, a parametrised index-to-one-hot decoder with enable, instantiated for r_out and r_in.

Test Plan:
- Binary op, FETCH_EN = 1, mem_ready tied high, start with ADD, ra = 2, rb = 3, rd = 1 → T0–T5 in 6 cycles.
  - r_out = 0x0004 in T3 and 0x0008 in T4; r_in = 0x0002 in T5; done pulses once; busy high for 6 cycles.
- Unary op, NOT (10001), ra = 1, rd = 0 → r_out = 0x0002 with z_in and alu_opcode = 10001 in T3.
  - T4: r_in = 0x0001 and done.
  - y_in and y_out never high.
- Wide op, MUL, ra = 6, rb = 3 → T5: lo_in with zlo_out; T6: hi_in with zhi_out; r_in stays 0 throughout.
- Memory wait and timeout:
  - mem_ready low for 4 cycles → T1 held 5 cycles, then completes normally.
  - mem_ready held low, MEM_TIMEOUT = 15 → err pulses after 15 cycles in T1, then IDLE; no r_in asserted.
- Illegal opcode 11111 → err pulse and return to IDLE, done never high. A start during busy has no effect.
- clr asserted in T4 of a DIV → next edge: IDLE, all outputs 0. A following ADD executes cleanly with the new operands.
